filter_window_sequencer: RTL and testbench
==========================================

Name: filter_window_sequencer

Overview:
- Sequences the 3x3 neighbourhood colour filters over a whole frame.
- For each output pixel it reads 9 neighbours from the source frame RAM, packs them into the filter's 108-bit window bus, and holds the window stable for the filter pipeline latency.
- It then writes the filtered 12-bit RGB444 result to the destination frame RAM.
- Sits between the frame buffers and any filter module with the color_data / filter_rgb_out interface.

Parameters:
- IMG_W, 160, frame width in pixels (>=2).
- IMG_H, 120, frame height in pixels (>=2).
- ADDR_W, 15, frame RAM address width; must hold IMG_W*IMG_H-1.
- FILTER_LAT, 4, clocks from a stable color_data to a valid filter output (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame pass when idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pixel write.
- rd_en  out  1  source RAM read strobe.
- rd_addr  out  ADDR_W  source RAM address.
- rd_data  in  12  source pixel; valid exactly 1 clk after rd_en.
- color_data  out  108  window bus to the filter.
- filter_rgb_in  in  12  filter result.
- wr_en  out  1  destination RAM write strobe.
- wr_addr  out  ADDR_W  destination RAM address.
- wr_data  out  12  destination pixel.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; busy, done, rd_en and wr_en are 0; rd_addr, wr_addr, wr_data and color_data are 0; the x/y counters are 0. Reset asserted mid-frame aborts immediately with no further writes.
- color_data packing, 12 bits per neighbour:
  - [107:96] centre, [95:84] left, [83:72] right, [71:60] up, [59:48] down.
  - [47:36] up-left, [35:24] up-right, [23:12] down-left, [11:0] down-right.
- Fetch order k=0..8: centre, left, right, up, down, up-left, up-right, down-left, down-right.
- Neighbour coordinate = (x+dx, y+dy), each axis clamped to [0, IMG_W-1] / [0, IMG_H-1] (edge replication). Address = y*IMG_W + x, computed incrementally (no multiplier in the address path).
- FSM:
  - IDLE: on start go to FETCH with x=y=0, k=0, busy=1. start is ignored in every state except IDLE.
  - FETCH (9 cycles): rd_en=1 with rd_addr for neighbour k; rd_data from the previous cycle is captured into slot k-1; k increments; after k=8 go to LAST.
  - LAST (1 cycle): rd_en=0; slot 8 is captured. color_data then updates as one complete window; partially filled windows are never visible on the bus.
  - HOLD (FILTER_LAT cycles): color_data held constant.
  - WRITE (1 cycle): wr_en=1, wr_addr=y*IMG_W+x, wr_data=filter_rgb_in. Advance x; on x wrap (x=IMG_W-1) set x=0 and y=y+1. If (x,y) was (IMG_W-1, IMG_H-1) go to DONE, else go to FETCH.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- Timing: 11+FILTER_LAT clocks per pixel. A frame takes IMG_W*IMG_H*(11+FILTER_LAT)+2 clocks from start to the done pulse.
- color_data holds its last window while IDLE. Exactly one write per pixel, in raster order, never two writes to one address.

Optional Feature:
- Macro ZERO_BORDER_EN.
- Defined: neighbours whose unclamped coordinate lies outside the frame are packed as 12'h000. The clamped read is still issued, so per-pixel timing is unchanged.
- Undefined: edge replication as above.

Test Plan:
- Basic fetch: IMG_W=4, IMG_H=3, FILTER_LAT=4, RAM[i]=i. Start -> first rd_addr sequence is 0,0,1,0,4,0,1,4,5. color_data at HOLD = {000,000,001,000,004,000,001,004,005}.
- Full frame: same setup, pass-through stub filter (centre after 4 clocks) -> 12 writes, addr 0..11, wr_data=i. done pulses exactly 12*15+2=182 clocks after start.
- Corner (3,2) under ZERO_BORDER_EN -> right, down, up-right, down-left and down-right slots are 000. Centre = 00B, left = 00A, up = 007, up-left = 006.
- start pulsed during busy, and again on the done cycle -> ignored, no extra writes. A start one cycle after done launches a new frame.
- Reset asserted in HOLD of pixel 5 -> all outputs 0 immediately. No wr_en until a new start, which begins at addr 0.

Source files
------------

// File: rtl/filter_window_sequencer.sv
// Walks a frame in raster order, gathers each pixel's 3x3 neighbourhood into a 108-bit
// window for an external filter, then writes the filter result back. Option: ZERO_BORDER_EN.
module filter_window_sequencer #(
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int ADDR_W     = 15,
    parameter int FILTER_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic [107:0]      color_data,
    input  logic [11:0]       filter_rgb_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_HOLD, S_WRITE, S_DONE} state_t;

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = (FILTER_LAT > 9) ? $clog2(FILTER_LAT) : 4;
    localparam logic [XW-1:0]     X_MAX  = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_MAX  = YW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
    localparam logic [CW-1:0]     K_LAST = CW'(8);
    localparam logic [CW-1:0]     H_LAST = CW'(FILTER_LAT - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] base_q, base_d;       // y*IMG_W, kept up to date by addition
    logic [107:0]      color_q;
    logic [11:0]       sh_q [0:7];
    logic [11:0]       cap_val;

    // Clamped neighbour rows/columns give edge replication for free.
    logic [XW-1:0]     col_l, col_r, col;
    logic [ADDR_W-1:0] row_u, row_d, row, nb_addr;

    always_comb begin
        col_l = (x_q == '0)    ? x_q    : x_q - 1'b1;
        col_r = (x_q == X_MAX) ? x_q    : x_q + 1'b1;
        row_u = (y_q == '0)    ? base_q : base_q - W_A;
        row_d = (y_q == Y_MAX) ? base_q : base_q + W_A;
        case (cnt_q)
            CW'(1):  begin row = base_q; col = col_l; end
            CW'(2):  begin row = base_q; col = col_r; end
            CW'(3):  begin row = row_u;  col = x_q;   end
            CW'(4):  begin row = row_d;  col = x_q;   end
            CW'(5):  begin row = row_u;  col = col_l; end
            CW'(6):  begin row = row_u;  col = col_r; end
            CW'(7):  begin row = row_d;  col = col_l; end
            CW'(8):  begin row = row_d;  col = col_r; end
            default: begin row = base_q; col = x_q;   end
        endcase
        nb_addr = row + ADDR_W'(col);
    end

`ifdef ZERO_BORDER_EN
    function automatic logic slot_oob(input logic [3:0] s, input logic l, r, u, d);
        case (s)
            4'd1:    return l;
            4'd2:    return r;
            4'd3:    return u;
            4'd4:    return d;
            4'd5:    return l | u;
            4'd6:    return r | u;
            4'd7:    return l | d;
            4'd8:    return r | d;
            default: return 1'b0;
        endcase
    endfunction

    logic [3:0] cap_slot;
    assign cap_slot = (state_q == S_LAST) ? 4'd8 : 4'(cnt_q - 1'b1);
    assign cap_val  = slot_oob(cap_slot, x_q == '0, x_q == X_MAX, y_q == '0, y_q == Y_MAX)
                      ? 12'h000 : rd_data;
`else
    assign cap_val = rd_data;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_FETCH;
                cnt_d   = '0;
                x_d     = '0;
                y_d     = '0;
                base_d  = '0;
            end
            S_FETCH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == K_LAST) state_d = S_LAST;
            end
            S_LAST: begin
                cnt_d   = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == H_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d   = '0;
                state_d = S_FETCH;
                if (x_q == X_MAX) begin
                    x_d = '0;
                    if (y_q == Y_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        y_d    = y_q + 1'b1;
                        base_d = base_q + W_A;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE) && (state_q != S_DONE);
        done    = (state_q == S_DONE);
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state_q == S_FETCH) begin
            rd_en   = 1'b1;
            rd_addr = nb_addr;
        end
        if (state_q == S_WRITE) begin
            wr_en   = 1'b1;
            wr_addr = base_q + ADDR_W'(x_q);
            wr_data = filter_rgb_in;
        end
    end

    // NOTE: the staging slots are always overwritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_FETCH && cnt_q != '0) sh_q[3'(cnt_q - 1'b1)] <= cap_val;
    end

    // The bus only changes once all nine slots are in, so the filter never sees a partial window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  color_q <= '0;
        else if (state_q == S_LAST) color_q <= {sh_q[0], sh_q[1], sh_q[2], sh_q[3],
                                                sh_q[4], sh_q[5], sh_q[6], sh_q[7], cap_val};
    end

    assign color_data = color_q;
endmodule

// File: tb/tb_filter_window_sequencer.sv
// Randomised and directed bench for filter_window_sequencer on a 4x3 frame with a model
// that derives windows, read addresses, write results and frame timing from coordinates.
module tb_filter_window_sequencer;
    localparam int W = 4, H = 3, N = W * H, LAT = 4, AW = 15;
    localparam int FRAME_CYC = N * (11 + LAT) + 2;

    logic          clk = 1'b0, reset, start;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [11:0]   rd_data, filter_rgb_in, wr_data;
    logic [107:0]  color_data;

    filter_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FILTER_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .color_data(color_data),
        .filter_rgb_in(filter_rgb_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    always #5 clk = ~clk;

    logic [11:0] ram [0:N-1];
    int          filt_mode;
    int          total = 0, bad = 0;
    logic [107:0] wc[$];
    int           wa[$], wd[$], rq[$];

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    function automatic logic [11:0] filt_fn(input logic [107:0] w);
        logic [11:0] acc = 12'h000;
        if (filt_mode == 0) return w[107:96];
        for (int s = 0; s < 9; s++) acc = acc + 12'(s + 1) * w[107 - 12 * s -: 12];
        return acc;
    endfunction

    // Stub filter: result appears LAT clocks after the window is presented.
    logic [11:0] fpipe [0:LAT-1];
    always @(posedge clk) begin
        fpipe[0] <= filt_fn(color_data);
        for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
    end
    assign filter_rgb_in = fpipe[LAT-1];

    always @(negedge clk) if (!reset) begin
        if (wr_en) begin wa.push_back(int'(wr_addr)); wd.push_back(int'(wr_data)); wc.push_back(color_data); end
        if (rd_en) rq.push_back(int'(rd_addr));
    end

    const int DX [9] = '{0, -1, 1, 0, 0, -1, 1, -1, 1};
    const int DY [9] = '{0, 0, 0, -1, 1, -1, -1, 1, 1};

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    function automatic int nb_addr(input int x, input int y, input int k);
        return clampi(y + DY[k], H - 1) * W + clampi(x + DX[k], W - 1);
    endfunction

    function automatic logic [107:0] model_win(input int x, input int y);
        logic [107:0] w;
        for (int k = 0; k < 9; k++) begin
            w[107 - 12 * k -: 12] = ram[nb_addr(x, y, k)];
`ifdef ZERO_BORDER_EN
            if (x + DX[k] < 0 || x + DX[k] >= W || y + DY[k] < 0 || y + DY[k] >= H)
                w[107 - 12 * k -: 12] = 12'h000;
`endif
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [107:0] obs, input logic [107:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one frame; optional stray start pulses mid-frame, on the done cycle, and
    // (restart) in the cycle after done. Returns with start low unless restarting.
    task automatic run_frame(input bit do_start, input int inject_at, input bit start_on_done,
                             input bit restart);
        int cyc = 1;
        wc.delete(); wa.delete(); wd.delete(); rq.delete();
        if (do_start) begin @(negedge clk); start = 1'b1; end
        while (cyc < 2 * FRAME_CYC) begin
            @(negedge clk);
            cyc++;
            if (done) begin start = start_on_done; break; end
            start = (cyc == inject_at);
        end
        check("frame_cycles", 108'(cyc), 108'(FRAME_CYC));
        @(negedge clk);
        start = restart;
    endtask

    task automatic verify_frame();
        check("wr_count", 108'(wa.size()), 108'(N));
        check("rd_count", 108'(rq.size()), 108'(N * 9));
        for (int p = 0; p < N && p < wa.size(); p++) begin
            check("wr_addr", 108'(wa[p]), 108'(p));
            check("wr_window", wc[p], model_win(p % W, p / W));
            check("wr_data", 108'(wd[p]), 108'(filt_fn(model_win(p % W, p / W))));
        end
        for (int i = 0; i < N * 9 && i < rq.size(); i++)
            check("rd_addr", 108'(rq[i]), 108'(nb_addr((i / 9) % W, (i / 9) / W, i % 9)));
    endtask

    function automatic logic [107:0] all_outs();
        return {busy, done, rd_en, wr_en, 60'(rd_addr), 60'(wr_addr), 12'(wr_data)} | color_data;
    endfunction

    initial begin
        logic [107:0] first_win, corner_win;
        int first_rd [9] = '{0, 0, 1, 0, 4, 0, 1, 4, 5};
        int cyc;
`ifdef ZERO_BORDER_EN
        first_win  = {12'h000, 12'h000, 12'h001, 12'h000, 12'h004, 12'h000, 12'h000, 12'h000, 12'h005};
        corner_win = {12'h00B, 12'h00A, 12'h000, 12'h007, 12'h000, 12'h006, 12'h000, 12'h000, 12'h000};
`else
        first_win  = {12'h000, 12'h000, 12'h001, 12'h000, 12'h004, 12'h000, 12'h001, 12'h004, 12'h005};
        corner_win = {12'h00B, 12'h00A, 12'h00B, 12'h007, 12'h00B, 12'h006, 12'h007, 12'h00A, 12'h00B};
`endif
        reset = 1'b1; start = 1'b0; filt_mode = 0;
        for (int i = 0; i < N; i++) ram[i] = 12'(i);
        repeat (2) @(negedge clk);
        check("reset_busy", 108'(busy), 108'(0));
        check("reset_outs", all_outs(), 108'(0));
        reset = 1'b0;

        // Identity RAM, pass-through filter.
        run_frame(1'b1, 0, 1'b0, 1'b0);
        verify_frame();
        for (int k = 0; k < 9; k++) check("first_rd", 108'(rq[k]), 108'(first_rd[k]));
        check("first_window", wc[0], first_win);
        check("corner_window", wc[N-1], corner_win);
        for (int p = 0; p < N; p++) check("passthru_data", 108'(wd[p]), 108'(p));

        // Stray starts while busy and on the done cycle must not relaunch.
        run_frame(1'b1, 50, 1'b1, 1'b0);
        verify_frame();
        wa.delete();
        repeat (30) @(negedge clk);
        check("idle_no_writes", 108'(wa.size()), 108'(0));
        check("idle_busy", 108'(busy), 108'(0));
        check("idle_holds_window", color_data, corner_win);

        // Start on the done cycle, then again one cycle later: second one launches.
        run_frame(1'b1, 0, 1'b1, 1'b1);
        verify_frame();
        run_frame(1'b0, 0, 1'b0, 1'b0);
        verify_frame();

        // Reset during HOLD of pixel 5 (HOLD occupies frame cycles 87..90).
        wa.delete(); wd.delete(); wc.delete(); rq.delete();
        @(negedge clk); start = 1'b1; cyc = 1;
        @(negedge clk); start = 1'b0; cyc = 2;
        while (cyc < 88) begin @(negedge clk); cyc++; end
        check("pre_reset_writes", 108'(wa.size()), 108'(5));
        #1 reset = 1'b1;
        #1 check("mid_reset_outs", all_outs(), 108'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("post_reset_writes", 108'(wa.size()), 108'(5));
        check("post_reset_busy", 108'(busy), 108'(0));
        run_frame(1'b1, 0, 1'b0, 1'b0);
        verify_frame();

        // Random images through a weighted filter that exposes every slot position.
        filt_mode = 1;
        repeat (4) begin
            for (int i = 0; i < N; i++) ram[i] = 12'($urandom_range(0, 4095));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_frame(1'b1, $urandom_range(2, FRAME_CYC - 2), 1'($urandom_range(0, 1)), 1'b0);
            verify_frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
